// File: rtl/pll_ctrl_pkg.sv
// rtl/pll_ctrl_pkg.sv - shared types, defaults and sizing helpers for the PLL reset controller
// Purpose: FSM state encoding (also driven on the debug state port), default
//          parameter values and constant functions used to size counters.
// Ports:   none (package).
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 65536;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;
  localparam int DEF_SYNC_STAGES   = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bit width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pll_reset_ctrl_if.sv
// rtl/pll_reset_ctrl_if.sv - PLL-side and system-side signals of the reset controller
// Purpose: bundles the PLL handshake (pll_locked in, pll_rst out) and the
//          system reset/status outputs.
// Ports (signals):
//   pll_locked  PLL locked, asynchronous to clk
//   pll_rst     PLL reset, active-high
//   sys_rst_n   system reset level for the 12 MHz domain, active-low
//   ready       PLL locked and stable, system released
//   fault       sticky bring-up failure
//   retries     failed attempts in the current bring-up
//   state       encoded FSM state (debug)
// Modports: master = controller, slave = PLL/system side.
interface pll_reset_ctrl_if #(
  parameter int RETRY_W = 2
);
  import pll_ctrl_pkg::*;

  logic               pll_locked;
  logic               pll_rst;
  logic               sys_rst_n;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retries;
  state_t             state;

  modport master (
    input  pll_locked,
    output pll_rst, sys_rst_n, ready, fault, retries, state
  );

  modport slave (
    output pll_locked,
    input  pll_rst, sys_rst_n, ready, fault, retries, state
  );

endinterface

// File: rtl/pll_reset_ctrl_sync_bit.sv
// rtl/pll_reset_ctrl_sync_bit.sv - single-bit synchroniser with async clear
// Purpose: brings an asynchronous level into the clk domain through STAGES flops.
// Ports:
//   clk    sampling clock
//   rst_n  async active-low clear of every stage
//   d_i    asynchronous input
//   q_o    synchronised output (last stage)
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_ctrl.sv
// rtl/pll_reset_ctrl.sv - PLL reset sequencer and lock supervisor
// Purpose: pulses the PLL reset, waits for a synchronised lock, requires the
//          lock to stay stable before releasing the system reset, retries on
//          timeout or early loss, and latches a fault when retries run out.
// Ports:
//   clk    50 MHz reference clock
//   rst_n  async active-low reset
//   bus    pll_reset_ctrl_if.master (pll_locked in; pll_rst, sys_rst_n,
//          ready, fault, retries, state out)
// Build option: PLL_AUTO_RELOCK_EN - lock loss in RUN restarts the bring-up
//          instead of latching FAULT.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pll_reset_ctrl_if.master        bus
);

  localparam int RETRY_W = clog2_min1(MAX_RETRIES + 1);
  // STABLE has to reach a count of STABLE_CYCLES itself, hence the +1.
  localparam int CNT_W   = clog2_min1(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES + 1));

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  // Entry into STABLE already consumed one synchronised lock sample, so the
  // release lands SYNC_STAGES+STABLE_CYCLES+1 edges after the first raw sample.
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_SAT      = '1;
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  logic               lock_s;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retries_q, retries_d;
  logic               pll_rst_q, sys_rst_n_q, ready_q, fault_q;
  logic               attempt_fail;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.pll_locked),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d      = state_q;
    retries_d    = retries_q;
    cnt_d        = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    attempt_fail = 1'b0;

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock is checked first so it wins against a same-cycle timeout.
        if (lock_s)                     state_d      = STABLE;
        else if (cnt_q == TIMEOUT_LAST) attempt_fail = 1'b1;
      end
      STABLE: begin
        if (!lock_s)                   attempt_fail = 1'b1;
        else if (cnt_q == STABLE_LAST) state_d      = RUN;
      end
      RUN: begin
        if (!lock_s) begin
`ifdef PLL_AUTO_RELOCK_EN
          state_d   = RESET_PLL;
          retries_d = '0;
`else
          state_d   = FAULT;
`endif
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = RESET_PLL;
    endcase

    if (attempt_fail) begin
      if (retries_q == RETRY_MAX) begin
        state_d = FAULT;
      end else begin
        state_d   = RESET_PLL;
        retries_d = retries_q + 1'b1;
      end
    end

    if (state_d == RUN)     retries_d = '0;
    if (state_d != state_q) cnt_d     = '0;
  end

  // Outputs are decoded from state_d so they change on the entering edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retries_q   <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      pll_rst_q   <= (state_d == RESET_PLL) || (state_d == FAULT);
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.ready     = ready_q;
  assign bus.fault     = fault_q;
  assign bus.retries   = retries_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb/tb_pll_reset_ctrl.sv - self-checking bench for pll_reset_ctrl
module tb_pll_reset_ctrl;

  localparam int RST  = 4;
  localparam int LT   = 32;
  localparam int SC   = 8;
  localparam int MAXR = 2;
  localparam int SYNC = 2;

  localparam int ST_RESET  = 0;
  localparam int ST_WAIT   = 1;
  localparam int ST_STABLE = 2;
  localparam int ST_RUN    = 3;
  localparam int ST_FAULT  = 4;

  localparam int K_RUN  = 0;
  localparam int K_FAIL = 1;
  localparam int K_LOSS = 2;

  localparam int NEVER = 999;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pll_reset_ctrl_if #(.RETRY_W(2)) bus ();

  pll_reset_ctrl #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (LT),
    .STABLE_CYCLES (SC),
    .MAX_RETRIES   (MAXR),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;        // edges after pll_rst falls until pll_locked is first sampled high
    int b;        // edges after that until it is sampled low again (0 = never)
    int ready_t;  // expected edge of ready rise, relative to bring-up start (-1 none)
    int rise_t;   // expected edge pll_rst rises again (-1 none)
    int retries;  // expected retries at the end of the attempt
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] exp_out(input int st, input int r);
    logic pr, sr, ft;
    pr = (st == ST_RESET) || (st == ST_FAULT);
    sr = (st == ST_RUN);
    ft = (st == ST_FAULT);
    return {3'(st), pr, sr, sr, ft, 2'(r)};
  endfunction

  function automatic logic [8:0] act_out();
    return {bus.state, bus.pll_rst, bus.sys_rst_n, bus.ready, bus.fault, bus.retries};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    bus.pll_locked = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_outputs_async", 32'(act_out()), 32'(exp_out(ST_RESET, 0)));
    repeat (2) @(negedge clk);
    check("reset_outputs_held", 32'(act_out()), 32'(exp_out(ST_RESET, 0)));
    rst_n = 1'b1;
  endtask

  // Timeline model of one attempt starting at the edge RESET_PLL is entered
  // (t=0, caller is at the negedge after it). The synchronised lock is seen
  // SYNC edges after the raw sample; every phase boundary follows from that.
  task automatic attempt(input int a, input int b, input int r_in,
                         output int kind, output int r_out, output bit faulted,
                         output int ready_t, output int rise_t, output int fall_t);
    int  f, e0, s, r, d, x, ev, end_t, ev_st, st, rr;
    bit  wins;
    logic prev_rst, prev_rdy;
    f    = RST;
    e0   = f + a;
    wins = (e0 + SYNC <= f + LT);
    s    = e0 + SYNC;
    r    = s + SC + 1;
    d    = e0 + b;
    x    = d + SYNC;
    faulted = 1'b0;
    if (!wins) begin
      kind = K_FAIL; ev = f + LT;
    end else if (b > 0 && x <= r) begin
      kind = K_FAIL; ev = x;
    end else if (b > 0) begin
      kind = K_LOSS; ev = x;
    end else begin
      kind = K_RUN; ev = r;
    end
    if (kind == K_FAIL) begin
      faulted = (r_in == MAXR);
      r_out   = faulted ? r_in : r_in + 1;
      ev_st   = faulted ? ST_FAULT : ST_RESET;
    end else begin
      r_out = 0;
`ifdef PLL_AUTO_RELOCK_EN
      ev_st = ST_RESET;
`else
      ev_st = ST_FAULT;
      faulted = (kind == K_LOSS);
`endif
    end
    end_t = (kind == K_RUN) ? r + 4 : ev;
    ready_t = -1; rise_t = -1; fall_t = -1;
    prev_rst = 1'b1; prev_rdy = 1'b0;
    for (int t = 1; t <= end_t; t++) begin
      bus.pll_locked = (t >= e0) && !(b > 0 && t >= d);
      @(negedge clk);
      if (t == ev && kind != K_RUN) begin st = ev_st;     rr = r_out; end
      else if (t < f)               begin st = ST_RESET;  rr = r_in;  end
      else if (!wins || t < s)      begin st = ST_WAIT;   rr = r_in;  end
      else if (t < r)               begin st = ST_STABLE; rr = r_in;  end
      else                          begin st = ST_RUN;    rr = 0;     end
      check($sformatf("outputs a=%0d b=%0d r=%0d t=%0d", a, b, r_in, t),
            32'(act_out()), 32'(exp_out(st, rr)));
      if (prev_rst && !bus.pll_rst && fall_t < 0) fall_t = t;
      if (!prev_rst && bus.pll_rst && rise_t < 0) rise_t = t;
      if (!prev_rdy && bus.ready && ready_t < 0)  ready_t = t;
      prev_rst = bus.pll_rst;
      prev_rdy = bus.ready;
    end
  endtask

  task automatic hold_fault(input int n, input int r);
    for (int i = 0; i < n; i++) begin
      bus.pll_locked = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("fault_sticky i=%0d", i), 32'(act_out()), 32'(exp_out(ST_FAULT, r)));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, r, ready_t, rise_t, fall_t, tries;
    bit faulted, done;

    tbl[0] = '{a: 10,    b: 0,  ready_t: 25, rise_t: -1, retries: 0};
    tbl[1] = '{a: 30,    b: 0,  ready_t: 45, rise_t: -1, retries: 0};  // lock ties the timeout
    tbl[2] = '{a: 31,    b: 0,  ready_t: -1, rise_t: 36, retries: 1};  // lock one edge too late
    tbl[3] = '{a: 10,    b: 5,  ready_t: -1, rise_t: 21, retries: 1};
    tbl[4] = '{a: 10,    b: 9,  ready_t: -1, rise_t: 25, retries: 1};  // drop seen on release edge
    tbl[5] = '{a: 10,    b: 10, ready_t: 25, rise_t: 26, retries: 0};  // loss in RUN
    tbl[6] = '{a: 1,     b: 0,  ready_t: 16, rise_t: -1, retries: 0};
    tbl[7] = '{a: NEVER, b: 0,  ready_t: -1, rise_t: 36, retries: 1};

    bus.pll_locked = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_reset();
      attempt(tbl[i].a, tbl[i].b, 0, kind, r, faulted, ready_t, rise_t, fall_t);
      check($sformatf("tbl%0d fall_t", i), 32'(fall_t), 32'(RST));
      check($sformatf("tbl%0d ready_t", i), 32'(ready_t), 32'(tbl[i].ready_t));
      check($sformatf("tbl%0d rise_t", i), 32'(rise_t), 32'(tbl[i].rise_t));
      check($sformatf("tbl%0d retries", i), 32'(bus.retries), 32'(tbl[i].retries));
    end

    // No lock at all: three reset pulses then a sticky fault with retries=2.
    do_reset();
    r = 0;
    for (int i = 0; i < 3; i++) begin
      attempt(NEVER, 0, r, kind, r, faulted, ready_t, rise_t, fall_t);
      check($sformatf("nolock%0d fall_t", i), 32'(fall_t), 32'(RST));
      check($sformatf("nolock%0d rise_t", i), 32'(rise_t), 32'(RST + LT));
    end
    check("nolock fault", 32'(bus.fault), 32'd1);
    check("nolock retries", 32'(bus.retries), 32'd2);
    hold_fault(20, 2);

    // Drop during STABLE, then a clean relock.
    do_reset();
    attempt(10, 5, 0, kind, r, faulted, ready_t, rise_t, fall_t);
    check("stable_drop ready_t", 32'(ready_t), 32'hFFFF_FFFF);
    check("stable_drop retries", 32'(bus.retries), 32'd1);
    attempt(5, 0, r, kind, r, faulted, ready_t, rise_t, fall_t);
    check("relock ready_t", 32'(ready_t), 32'(RST + 5 + SYNC + SC + 1));
    check("relock retries", 32'(bus.retries), 32'd0);

    // Lock loss in RUN.
    do_reset();
    attempt(3, 20, 0, kind, r, faulted, ready_t, rise_t, fall_t);
    check("run_loss sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
`ifdef PLL_AUTO_RELOCK_EN
    attempt(4, 0, 0, kind, r, faulted, ready_t, rise_t, fall_t);
    check("run_loss relock fall_t", 32'(fall_t), 32'(RST));
    check("run_loss relock ready_t", 32'(ready_t), 32'(RST + 4 + SYNC + SC + 1));
`else
    check("run_loss fault", 32'(bus.fault), 32'd1);
    hold_fault(20, 0);
`endif

    // Async reset while in WAIT_LOCK with retries=1.
    do_reset();
    attempt(NEVER, 0, 0, kind, r, faulted, ready_t, rise_t, fall_t);
    for (int t = 1; t <= RST + 4; t++) begin
      bus.pll_locked = 1'b0;
      @(negedge clk);
    end
    check("midwait state", 32'(act_out()), 32'(exp_out(ST_WAIT, 1)));
    do_reset();
    attempt(2, 0, 0, kind, r, faulted, ready_t, rise_t, fall_t);
    check("post_reset ready_t", 32'(ready_t), 32'(RST + 2 + SYNC + SC + 1));
    check("post_reset retries", 32'(bus.retries), 32'd0);

    // Randomised bring-ups against the timeline model.
    for (int n = 0; n < 30; n++) begin
      do_reset();
      r = 0; tries = 0; done = 1'b0;
      while (!done && tries < 8) begin
        int a, b;
        a = ($urandom_range(0, 9) < 7) ? int'($urandom_range(1, LT - SYNC + 2)) : NEVER;
        b = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, SYNC + SC + 4));
        attempt(a, b, r, kind, r, faulted, ready_t, rise_t, fall_t);
        tries++;
        if (kind == K_RUN) begin
          done = 1'b1;
        end else if (faulted) begin
          hold_fault(5, r);
          done = 1'b1;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
